// File: rtl/regression_feeder_pkg.sv
// regression_feeder_pkg: shared state encoding and default sizing for the regression blocks.
package regression_feeder_pkg;
    localparam int DW_DEF     = 20;
    localparam int AW_DEF     = 7;
    localparam int SETTLE_DEF = 2;
    typedef enum logic [2:0] {ST_IDLE, ST_PRIME, ST_STREAM, ST_DRAIN, ST_SETTLE, ST_DONE} state_e;
endpackage

// File: rtl/regression_feeder_sample_counter.sv
// sample_counter: read address generator with latched dataset length and last-address flag.
module sample_counter #(
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [AW:0]   n_i,
    input  logic          inc_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);
    logic [AW:0] cnt_q, n_q;
    // Counter is AW+1 bits so a full 2^AW dataset compares cleanly; it never advances past n-1.
    assign last_o = cnt_q == n_q - (AW+1)'(1);
    assign addr_o = cnt_q[AW-1:0];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            n_q   <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
            n_q   <= n_i;
        end else if (inc_i && !last_o) begin
            cnt_q <= cnt_q + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/regression_feeder.sv
// regression_feeder: streams a stored dataset into the coefficient unit, then settles and pulses done.
module regression_feeder
    import regression_feeder_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW:0]   n_samples,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_x,
    input  logic [DW-1:0] mem_y,
    output logic          en_out,
    output logic [DW-1:0] x_out,
    output logic [DW-1:0] y_out,
    output logic          busy,
    output logic          done
);
    localparam int SW = $clog2(SETTLE + 2);
    state_e        state_q, state_d;
    logic          rd_q, en_q, last, kill;
    logic [DW-1:0] x_q, y_q;
    logic [SW-1:0] sc_q;
    assign busy   = state_q != ST_IDLE;
    assign kill   = abort && busy;
    assign mem_rd = state_q == ST_PRIME || state_q == ST_STREAM;
    assign done   = state_q == ST_DONE;
    assign en_out = en_q;
    assign x_out  = x_q;
    assign y_out  = y_q;
    // Loading every IDLE cycle latches n_samples on the start cycle and parks the address at 0.
    sample_counter #(.AW(AW)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q == ST_IDLE),
        .n_i    (n_samples),
        .inc_i  (mem_rd),
        .addr_o (mem_addr),
        .last_o (last)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = n_samples == '0 ? ST_DONE : ST_PRIME;
            ST_PRIME,
            ST_STREAM: state_d = last ? ST_DRAIN : ST_STREAM;
            ST_DRAIN:  if (en_q && !rd_q) state_d = SETTLE == 0 ? ST_DONE : ST_SETTLE;
            ST_SETTLE: if (sc_q == SW'(SETTLE - 1)) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (kill) state_d = ST_IDLE;
    end
    // Read data lands one cycle after the strobe; rd_q marks it and en_q presents it a cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q <= 1'b0;
            en_q <= 1'b0;
            x_q  <= '0;
            y_q  <= '0;
            sc_q <= '0;
        end else begin
            rd_q <= mem_rd && !kill;
            en_q <= rd_q && !kill;
            sc_q <= state_q == ST_SETTLE ? sc_q + SW'(1) : '0;
            if (rd_q) begin
                x_q <= mem_x;
                y_q <= mem_y;
            end
        end
    end
endmodule

// File: tb/tb_regression_feeder.sv
// tb_regression_feeder: cycle-accurate checks of the feeder against a timeline model of each run.
module tb_regression_feeder;
    import regression_feeder_pkg::*;
    localparam int DW = 20, AW = 7, S = SETTLE_DEF;
    logic          clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
    logic [AW:0]   n_samples = '0;
    logic          mem_rd, en_out, busy, done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_x = '0, mem_y = '0, x_out, y_out;
    logic [DW-1:0] mx [128];
    logic [DW-1:0] my [128];
    int errors = 0, checks = 0, cyc = 0;
    regression_feeder #(.DW(DW), .AW(AW), .SETTLE(S)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .n_samples(n_samples),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_x(mem_x), .mem_y(mem_y),
        .en_out(en_out), .x_out(x_out), .y_out(y_out), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    always @(posedge clk) if (mem_rd) begin
        mem_x <= mx[mem_addr];
        mem_y <= my[mem_addr];
    end
    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, a, e);
        end
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_rd"}, 32'(mem_rd), 0);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_en"}, 32'(en_out), 0);
        chk({tag, "_x"}, 32'(x_out), 0);
        chk({tag, "_y"}, 32'(y_out), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask
    task automatic fill(input bit rnd);
        for (int i = 0; i < 128; i++) begin
            mx[i] = rnd ? DW'($urandom) : DW'(i + 1);
            my[i] = rnd ? DW'($urandom) : DW'(2 * i + 2);
        end
    endtask
    task automatic run(input int n, input int ab, input int rsa, input bit rs,
                       output int done_at, output int en_cnt);
        int k, L;
        bit alive, e_rd, e_en, e_done, e_busy;
        k = ab >= 0 ? ab : (rsa >= 0 ? rsa : 1 << 30);
        L = ab >= 0 ? ab + 2 : (rsa >= 0 ? rsa : n + S + 4);
        done_at = -1;
        en_cnt = 0;
        start = 1'b1;
        abort = 1'b0;
        n_samples = (AW+1)'(n);
        for (int c = 1; c <= L; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            alive = c <= k;
            e_rd   = alive && n > 0 && c <= n;
            e_en   = alive && n > 0 && c >= 3 && c <= n + 2;
            e_done = alive && (n == 0 ? c == 1 : c == n + 3 + S);
            e_busy = alive && (n == 0 ? c == 1 : c <= n + 3 + S);
            chk("mem_rd", 32'(mem_rd), 32'(e_rd));
            chk("en_out", 32'(en_out), 32'(e_en));
            chk("done", 32'(done), 32'(e_done));
            chk("busy", 32'(busy), 32'(e_busy));
            if (e_rd) chk("mem_addr", 32'(mem_addr), 32'(c - 1));
            if (e_en) begin
                chk("x_out", 32'(x_out), 32'(mx[c-3]));
                chk("y_out", 32'(y_out), 32'(my[c-3]));
            end
            if (en_out === 1'b1) en_cnt++;
            if (done === 1'b1) done_at = c;
            start = rs && c >= 2 && c <= 4;
            abort = c == ab;
            n_samples = (AW+1)'($urandom_range(0, 128));
            if (c == rsa) begin
                #2 rst = 1'b0;
                #1 chk_zero("async_rst");
                #3 rst = 1'b1;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask
    typedef struct {
        int n; int ab; int rsa; bit rs; int exp_done; int exp_en;
    } vec_t;
    vec_t vecs [8];
    initial begin
        int d, e, n, ab;
        bit rs;
        vecs[0] = '{4, -1, -1, 0, 9, 4};
        vecs[1] = '{0, -1, -1, 0, 1, 0};
        vecs[2] = '{128, -1, -1, 0, 133, 128};
        vecs[3] = '{1, -1, -1, 0, 6, 1};
        vecs[4] = '{6, -1, -1, 1, 11, 6};
        vecs[5] = '{10, 5, -1, 0, -1, 3};
        vecs[6] = '{10, -1, -1, 0, 15, 10};
        vecs[7] = '{8, -1, 4, 0, -1, 2};
        fill(0);
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            run(vecs[i].n, vecs[i].ab, vecs[i].rsa, vecs[i].rs, d, e);
            chk($sformatf("vec%0d_done_cycle", i), 32'(d), 32'(vecs[i].exp_done));
            chk($sformatf("vec%0d_en_count", i), 32'(e), 32'(vecs[i].exp_en));
        end
        run(5, -1, -1, 0, d, e);
        chk("post_rst_done_cycle", 32'(d), 32'(5 + 3 + S));
        for (int r = 0; r < 12; r++) begin
            fill(1);
            n = $urandom_range(0, 24);
            ab = $urandom_range(0, 2) == 0 ? $urandom_range(1, n + 6) : -1;
            rs = ab < 0 && n > 0 && $urandom_range(0, 1) == 1;
            run(n, ab, -1, rs, d, e);
            if (ab < 0) begin
                chk("rand_done_cycle", 32'(d), 32'(n == 0 ? 1 : n + 3 + S));
                chk("rand_en_count", 32'(e), 32'(n));
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regression_feeder.md
REGRESSION_FEEDER -- requirements
Module: regression_feeder

Interface
REQ-001 Parameter DW, default 20, width of each x and y sample.
REQ-002 Parameter AW, default 7, sample-memory address width; max dataset 2^AW samples.
REQ-003 Parameter SETTLE, default 2, idle cycles after the stream before done, letting the coefficient unit finish xbar/ybar/B0/B1.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request to stream one dataset; sampled only in IDLE.
REQ-007 abort  input  1  cancel an in-progress stream.
REQ-008 n_samples  input  AW+1  dataset length, 0..2^AW, sampled with start.
REQ-009 mem_rd  output  1  sample-memory read strobe.
REQ-010 mem_addr  output  AW  sample-memory read address.
REQ-011 mem_x, mem_y  input  DW each  memory read data, valid exactly one cycle after mem_rd.
REQ-012 en_out  output  1  sample-valid enable to the coefficient unit.
REQ-013 x_out, y_out  output  DW each  sample presented with en_out.
REQ-014 busy  output  1  high from PRIME through DONE inclusive.
REQ-015 done  output  1  one-cycle pulse when dataset and settle period complete.

Function
REQ-016 States SHALL be IDLE, PRIME, STREAM, DRAIN, SETTLE, DONE.
REQ-017 IDLE: start=1 and n_samples>0 -> PRIME; start=1 and n_samples=0 -> DONE (no reads, no en_out); else stay.
REQ-018 Cycle numbering: start sampled high in IDLE at cycle 0.
REQ-019 PRIME (cycle 1): mem_rd=1, mem_addr=0; next STREAM if n>1, else DRAIN.
REQ-020 STREAM: mem_rd=1, address increments by 1 per cycle; reads issued cycles 1..n at addresses 0..n-1; exits to DRAIN after address n-1 is issued.
REQ-021 mem_x/mem_y SHALL be registered into x_out/y_out, with en_out registered alongside; en_out high exactly cycles 3..n+2, contiguous, carrying sample k in cycle k+3.
REQ-022 DRAIN: mem_rd=0; holds until the last sample has been presented, then SETTLE.
REQ-023 SETTLE: en_out=0 for SETTLE cycles (n+3..n+2+SETTLE), then DONE.
REQ-024 DONE: done=1 for exactly one cycle (cycle n+3+SETTLE, or cycle 1 when n=0), then IDLE.
REQ-025 mem_addr SHALL never exceed n-1; n=2^AW SHALL read addresses 0..2^AW-1 without wrap, with the counter held at AW+1 bits.
REQ-026 start while not in IDLE SHALL be ignored; n_samples is latched at start and later changes are ignored.
REQ-027 abort=1 in any non-IDLE state -> IDLE next cycle; mem_rd, en_out, and busy drop that edge; no done pulse; abort wins over every other transition.
REQ-028 x_out/y_out SHALL hold their last value while en_out=0; consumers ignore them.

Reset
REQ-029 rst low SHALL asynchronously force IDLE, counters 0, and mem_rd, mem_addr, en_out, x_out, y_out, busy, and done all 0.
REQ-030 Reset mid-stream SHALL truncate the stream with no done; after release, the block accepts start from the first rising edge.

Structure
REQ-031 The state enum and default DW/AW/SETTLE SHALL live in the shared regression package used by the coefficient datapath and control unit.
REQ-032 The control FSM SHALL be one registered-state process plus a separate next-state/output process.
REQ-033 The sample-address/remaining-count logic SHALL be one sub-module, sample_counter (load, increment, terminal flag).

Verification
REQ-034 n=4, mem x={1,2,3,4}, y={2,4,6,8}, SETTLE=2 -> en_out high cycles 3-6 with x/y pairs in order, done at cycle 9, busy cycles 1-9.
REQ-035 n=0 -> done at cycle 1, mem_rd and en_out never asserted.
REQ-036 n=128 (AW=7) -> 128 contiguous en_out cycles, last mem_addr=127, done at cycle 133.
REQ-037 n=10, abort at cycle 5 -> en_out low from cycle 6, busy low, no done, and a fresh start at cycle 8 streams normally.
REQ-038 n=6, start re-asserted at cycles 2-4 -> ignored, and exactly 6 en_out cycles occur.
REQ-039 n=8, rst low at cycle 4 -> all outputs 0 immediately, asynchronously, with no done after release.
